fetch_decode_queue: RTL and testbench

//  Instruction queue between the fetch stage and decode: buffers {pc, instr} pairs from fetch.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_decode_queue.sv | 123 ++++++++++++
 tb/tb_fetch_decode_queue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared front-end types: default XLEN, NOP encoding, fetch/decode queue entry
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] instr;
   } fdq_entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } fdq_occ_e;

endpackage

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - fetch-to-decode {pc, instr} queue with flush
// FDQ_BYPASS_EN: empty queue forwards input straight to decode when decode is ready.
module fetch_decode_queue
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = XLEN_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_instr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   fdq_occ_e         occ_q, occ_d;
   fdq_entry_t       mem_q [DEPTH];
   fdq_entry_t       mem_d [DEPTH];

   logic       flush_eff;
   logic       full;
   logic       empty;
   logic       bypass;
   logic       push;
   logic       wr_en;
   logic       rd_en;
   fdq_entry_t head;

   // Reset in flight looks to both neighbours exactly like a redirect.
   always_comb begin
      flush_eff = flush | rst;
      full      = (occ_q == OCC_FULL);
      empty     = (occ_q == OCC_EMPTY);
      in_ready  = ~full & ~flush_eff;
`ifdef FDQ_BYPASS_EN
      bypass    = empty & in_valid & out_ready & ~flush_eff;
`else
      bypass    = 1'b0;
`endif
      out_valid = (~empty | bypass) & ~flush_eff;
      push      = in_valid & in_ready;
      wr_en     = push & ~bypass;
      rd_en     = out_valid & out_ready & ~bypass;
      head      = mem_q[rd_ptr_q];
      count     = count_q;
   end

   always_comb begin
      out_pc    = '0;
      out_instr = XLEN'(NOP_INSTR);
      if (bypass) begin
         out_pc    = in_pc;
         out_instr = in_instr;
      end else if (out_valid) begin
         out_pc    = head.pc;
         out_instr = head.instr;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = '{pc: in_pc, instr: in_instr};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_eff) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   always_comb begin
      occ_d = OCC_PARTIAL;
      if (count_d == '0) begin
         occ_d = OCC_EMPTY;
      end else if (count_d == CNT_W'(DEPTH)) begin
         occ_d = OCC_FULL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         occ_q    <= OCC_EMPTY;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - directed table-driven bench for fetch_decode_queue
module tb_fetch_decode_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  count;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic        rst;
      logic        flush;
      logic        iv;
      logic [31:0] pc;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_pc;
      logic [2:0]  e_cnt;
      logic        chk_data;
   } vec_t;

   vec_t vecs[$];

   fetch_decode_queue #(.DEPTH(4), .XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .count     (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return 32'hDEAD_0000 ^ pc;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                      input logic ordy, input logic e_ir, input logic e_ov,
                      input logic [31:0] e_pc, input logic [2:0] e_cnt, input logic chk_data);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_cnt = e_cnt; v.chk_data = chk_data;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                        input logic ordy);
      rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = instr_of(pc); out_ready = ordy;
   endtask

   task automatic check_outputs(input string tag, input logic e_ir, input logic e_ov,
                                input logic [31:0] e_pc, input logic [2:0] e_cnt,
                                input logic chk_data);
      check({tag, " in_ready"}, 32'(in_ready), 32'(e_ir));
      check({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
      check({tag, " count"}, 32'(count), 32'(e_cnt));
      if (chk_data) begin
         check({tag, " out_pc"}, out_pc, e_ov ? e_pc : 32'h0);
         check({tag, " out_instr"}, out_instr, e_ov ? instr_of(e_pc) : NOP);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      //   rst f  iv  pc        or  ir ov  e_pc      cnt chk
      add(1, 0, 0, 32'h0,    0,  0, 0, 32'h0,    0,  1);   // reset held, 2nd cycle
      add(0, 0, 0, 32'h0,    0,  1, 0, 32'h0,    0,  1);   // idle after reset
      add(0, 0, 1, 32'h0,    0,  1, 0, 32'h0,    0,  1);   // fill
      add(0, 0, 1, 32'h4,    0,  1, 1, 32'h0,    1,  1);
      add(0, 0, 1, 32'h8,    0,  1, 1, 32'h0,    2,  1);
      add(0, 0, 1, 32'hC,    0,  1, 1, 32'h0,    3,  1);
      add(0, 0, 1, 32'h10,   0,  0, 1, 32'h0,    4,  1);   // 5th push refused
      add(0, 0, 0, 32'h0,    0,  0, 1, 32'h0,    4,  1);
      add(0, 0, 1, 32'h10,   1,  0, 1, 32'h0,    4,  1);   // full: pop, push refused
      add(0, 0, 0, 32'h0,    1,  1, 1, 32'h4,    3,  1);
      add(0, 0, 0, 32'h0,    1,  1, 1, 32'h8,    2,  1);
      add(0, 0, 0, 32'h0,    1,  1, 1, 32'hC,    1,  1);
      add(0, 0, 0, 32'h0,    1,  1, 0, 32'h0,    0,  1);   // drained
      add(0, 0, 1, 32'h20,   0,  1, 0, 32'h0,    0,  1);
      add(0, 0, 1, 32'h24,   0,  1, 1, 32'h20,   1,  1);
      for (int k = 0; k < 10; k++) begin
         add(0, 0, 1, 32'h28 + 32'(4 * k), 1, 1, 1, 32'h20 + 32'(4 * k), 2, 1);
      end
      add(0, 0, 0, 32'h0,    0,  1, 1, 32'h48,   2,  1);
      add(0, 0, 1, 32'h4C,   0,  1, 1, 32'h48,   2,  1);
      add(0, 1, 1, 32'h50,   1,  0, 0, 32'h0,    3,  0);   // flush cycle
      add(0, 0, 0, 32'h0,    0,  1, 0, 32'h0,    0,  1);
      add(0, 0, 1, 32'h60,   0,  1, 0, 32'h0,    0,  1);
      add(0, 0, 0, 32'h0,    0,  1, 1, 32'h60,   1,  1);
      add(0, 0, 0, 32'h0,    1,  1, 1, 32'h60,   1,  1);
      add(0, 0, 0, 32'h0,    1,  1, 0, 32'h0,    0,  1);
      add(0, 0, 1, 32'h70,   0,  1, 0, 32'h0,    0,  1);
      add(0, 0, 1, 32'h74,   0,  1, 1, 32'h70,   1,  1);
      add(1, 0, 1, 32'h78,   1,  0, 0, 32'h0,    2,  0);   // reset mid-operation
      add(0, 0, 0, 32'h0,    1,  1, 0, 32'h0,    0,  1);

      @(posedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         #1;
         drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
         #3;
         check_outputs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_pc,
                       vecs[i].e_cnt, vecs[i].chk_data);
         @(posedge clk);
      end

      // Empty queue, decode ready, fetch presents 0x100.
      #1;
      drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
      #3;
`ifdef FDQ_BYPASS_EN
      check_outputs("byp_same", 1'b1, 1'b1, 32'h100, 3'd0, 1'b1);
`else
      check_outputs("byp_same", 1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
`endif
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      #3;
`ifdef FDQ_BYPASS_EN
      check_outputs("byp_next", 1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
`else
      check_outputs("byp_next", 1'b1, 1'b1, 32'h100, 3'd1, 1'b1);
`endif
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #3;
      check_outputs("byp_after", 1'b1, 1'b0, 32'h0, 3'd0, 1'b1);
      @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
